// File: rtl/ysyx_25040111_lsu_scoreboard.sv
// Load scoreboard: per-register pending-load counters gate issue on RAW/WAW
// hazards and a global in-flight limit; load writebacks retire entries.
module ysyx_25040111_lsu_scoreboard #(
  parameter int NREG      = 16,
  parameter int AW        = 4,
  parameter int CNT_W     = 2,
  parameter int MAX_OUT   = 4,
  parameter int WAW_STALL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_ard,
  input  logic [AW-1:0]   iss_ar1,
  input  logic [AW-1:0]   iss_ar2,
  input  logic            iss_use1,
  input  logic            iss_use2,
  input  logic            iss_wen,
  input  logic            iss_load,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_ard,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic [7:0]      outstanding,
  output logic            err_underflow
);

  // Handshake: an instruction is accepted on a cycle where iss_valid and
  // iss_ready are both high; iss_ready never looks at iss_valid.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [7:0]       out_q;
  logic             err_q;

  logic            raw, waw, full, fire;
  logic            inc_en, dec_en, uf_hit;
  logic [NREG-1:0] inc_vec, dec_vec;

  // Hazards look only at registered counters; a same-cycle writeback does not bypass.
  always_comb begin
    raw = (iss_use1 && (cnt[iss_ar1] != '0)) || (iss_use2 && (cnt[iss_ar2] != '0));
    if (WAW_STALL != 0) waw = iss_wen && (cnt[iss_ard] != '0);
    else                waw = iss_wen && (cnt[iss_ard] == CNT_MAX);
    full      = iss_load && iss_wen && (out_q == 8'(MAX_OUT));
    iss_ready = !flush && !raw && !waw && !full;
    fire      = iss_valid && iss_ready;
    inc_en    = fire && iss_load && iss_wen && (iss_ard != '0);
    dec_en    = wb_valid && (wb_ard != '0) && (cnt[wb_ard] != '0);
    uf_hit    = wb_valid && (wb_ard != '0) && (cnt[wb_ard] == '0);
    inc_vec   = '0;
    dec_vec   = '0;
    if (inc_en) inc_vec[iss_ard] = 1'b1;
    if (dec_en) dec_vec[wb_ard]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      out_q <= '0;
    end else begin
      // Increment and decrement on the same register cancel out.
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++)
        cnt[i] <= cnt[i] + CNT_W'(inc_vec[i]) - CNT_W'(dec_vec[i]);
      out_q <= out_q + 8'(inc_en) - 8'(dec_en);
      if (uf_hit) err_q <= 1'b1;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NREG; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign outstanding   = out_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu_scoreboard.sv
// Bench for the load scoreboard: directed vector table, hand sequences for
// WAW relaxation / flush / reset, then random traffic against a counter model.
module tb_ysyx_25040111_lsu_scoreboard;

  typedef struct packed {
    logic        v;
    logic [3:0]  ard, ar1, ar2;
    logic        u1, u2, wen, ld, wbv;
    logic [3:0]  wba;
    logic        fl;
    logic        rdy;
    logic [15:0] busy;
    logic [7:0]  out;
    logic        err;
  } vec_t;

  logic        clock, reset;
  logic        iss_valid, iss_use1, iss_use2, iss_wen, iss_load, wb_valid, flush;
  logic [3:0]  iss_ard, iss_ar1, iss_ar2, wb_ard;
  logic        rdy_s, err_s, rdy_r, err_r;
  logic [15:0] busy_s, busy_r;
  logic [7:0]  out_s, out_r;

  int n_pass = 0;
  int n_total = 0;

  int cnt_m [2][16];
  int out_m [2];
  bit err_m [2];

  vec_t tbl[$];

  ysyx_25040111_lsu_scoreboard #(.WAW_STALL(1)) u_dut (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(rdy_s),
    .iss_ard(iss_ard), .iss_ar1(iss_ar1), .iss_ar2(iss_ar2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_wen(iss_wen), .iss_load(iss_load),
    .wb_valid(wb_valid), .wb_ard(wb_ard), .flush(flush),
    .busy_vec(busy_s), .outstanding(out_s), .err_underflow(err_s)
  );

  ysyx_25040111_lsu_scoreboard #(.WAW_STALL(0)) u_dut_relax (
    .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_ready(rdy_r),
    .iss_ard(iss_ard), .iss_ar1(iss_ar1), .iss_ar2(iss_ar2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_wen(iss_wen), .iss_load(iss_load),
    .wb_valid(wb_valid), .wb_ard(wb_ard), .flush(flush),
    .busy_vec(busy_r), .outstanding(out_r), .err_underflow(err_r)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: act=still running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit v, int ard, int ar1, bit u1, int ar2, bit u2, bit wen,
                              bit ld, bit wbv, int wba, bit fl, bit rdy, int busy, int out, bit err);
    vec_t t;
    t.v = v; t.ard = 4'(ard); t.ar1 = 4'(ar1); t.u1 = u1; t.ar2 = 4'(ar2); t.u2 = u2;
    t.wen = wen; t.ld = ld; t.wbv = wbv; t.wba = 4'(wba); t.fl = fl;
    t.rdy = rdy; t.busy = 16'(busy); t.out = 8'(out); t.err = err;
    return t;
  endfunction

  function automatic vec_t f_ld(int ard, bit rdy, int busy, int out, bit err);
    return mk(1, ard, 0, 0, 0, 0, 1, 1, 0, 0, 0, rdy, busy, out, err);
  endfunction

  function automatic vec_t f_ldwb(int ard, int wba, bit rdy, int busy, int out, bit err);
    return mk(1, ard, 0, 0, 0, 0, 1, 1, 1, wba, 0, rdy, busy, out, err);
  endfunction

  function automatic vec_t f_wb(int wba, int busy, int out, bit err);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, wba, 0, 1, busy, out, err);
  endfunction

  task automatic apply_vec(input vec_t t);
    iss_valid = t.v; iss_ard = t.ard; iss_ar1 = t.ar1; iss_ar2 = t.ar2;
    iss_use1 = t.u1; iss_use2 = t.u2; iss_wen = t.wen; iss_load = t.ld;
    wb_valid = t.wbv; wb_ard = t.wba; flush = t.fl;
  endtask

  task automatic step(input vec_t t, input bit relax, input string tag);
    @(negedge clock);
    apply_vec(t);
    #1;
    check({tag, "_ready"}, relax ? rdy_r : rdy_s, t.rdy);
    @(posedge clock);
    #1;
    check({tag, "_busy"}, relax ? busy_r : busy_s, t.busy);
    check({tag, "_outstanding"}, relax ? out_r : out_s, t.out);
    check({tag, "_err"}, relax ? err_r : err_s, t.err);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    apply_vec('0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) cnt_m[k][i] = 0;
      out_m[k] = 0;
      err_m[k] = 1'b0;
    end
  endtask

  // Reference: k=0 stalls on any pending destination, k=1 allows stacking up to 3.
  function automatic bit m_ready(int k);
    bit raw, waw, full;
    raw  = (iss_use1 && cnt_m[k][iss_ar1] != 0) || (iss_use2 && cnt_m[k][iss_ar2] != 0);
    waw  = iss_wen && ((k == 0) ? (cnt_m[k][iss_ard] != 0) : (cnt_m[k][iss_ard] == 3));
    full = iss_load && iss_wen && (out_m[k] == 4);
    return !flush && !raw && !waw && !full;
  endfunction

  task automatic model_step(input int k, input bit rdy);
    bit dec, uf;
    if (flush) begin
      for (int i = 0; i < 16; i++) cnt_m[k][i] = 0;
      out_m[k] = 0;
    end else begin
      dec = wb_valid && wb_ard != 0 && cnt_m[k][wb_ard] != 0;
      uf  = wb_valid && wb_ard != 0 && cnt_m[k][wb_ard] == 0;
      if (iss_valid && rdy && iss_load && iss_wen && iss_ard != 0) begin
        cnt_m[k][iss_ard]++;
        out_m[k]++;
      end
      if (dec) begin
        cnt_m[k][wb_ard]--;
        out_m[k]--;
      end
      if (uf) err_m[k] = 1'b1;
    end
  endtask

  function automatic logic [15:0] m_busy(int k);
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = (cnt_m[k][i] != 0);
    return b;
  endfunction

  initial begin
    bit er_s, er_r;
    reset = 1'b1;
    apply_vec('0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy_s, 0);
    check("rst_outstanding", out_s, 0);
    check("rst_err", err_s, 0);
    check("rst_ready", rdy_s, 1);
    do_reset();

    // Load-use
    tbl.push_back(f_ld(5, 1, 'h20, 1, 0));
    tbl.push_back(mk(1, 8, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 'h20, 1, 0));
    tbl.push_back(mk(1, 8, 5, 1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    // Global limit
    tbl.push_back(f_ld(1, 1, 'h02, 1, 0));
    tbl.push_back(f_ld(2, 1, 'h06, 2, 0));
    tbl.push_back(f_ld(3, 1, 'h0E, 3, 0));
    tbl.push_back(f_ld(4, 1, 'h1E, 4, 0));
    tbl.push_back(f_ld(6, 0, 'h1E, 4, 0));
    tbl.push_back(f_ldwb(6, 2, 0, 'h1A, 3, 0));
    tbl.push_back(f_ld(6, 1, 'h5A, 4, 0));
    tbl.push_back(f_wb(1, 'h58, 3, 0));
    tbl.push_back(f_wb(3, 'h50, 2, 0));
    tbl.push_back(f_wb(4, 'h40, 1, 0));
    tbl.push_back(f_wb(6, 0, 0, 0));
    // WAW stall mode
    tbl.push_back(f_ld(7, 1, 'h80, 1, 0));
    tbl.push_back(f_ld(7, 0, 'h80, 1, 0));
    tbl.push_back(f_ldwb(7, 7, 0, 0, 0, 0));
    tbl.push_back(f_ld(7, 1, 'h80, 1, 0));
    tbl.push_back(f_wb(7, 0, 0, 0));
    // Register 0 and underflow
    tbl.push_back(f_ld(0, 1, 0, 0, 0));
    tbl.push_back(f_wb(0, 0, 0, 0));
    tbl.push_back(f_wb(9, 0, 0, 1));
    tbl.push_back(f_ld(9, 1, 'h200, 1, 1));
    tbl.push_back(f_wb(9, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Stacked loads to one destination in relaxed mode
    do_reset();
    step(f_ld(7, 1, 'h80, 1, 0), 1'b1, "relax_ld1");
    step(f_ld(7, 1, 'h80, 2, 0), 1'b1, "relax_ld2");
    step(f_ld(7, 1, 'h80, 3, 0), 1'b1, "relax_ld3");
    step(f_ld(7, 0, 'h80, 3, 0), 1'b1, "relax_ld4");
    step(f_wb(7, 'h80, 2, 0), 1'b1, "relax_wb1");
    step(f_wb(7, 'h80, 1, 0), 1'b1, "relax_wb2");
    step(f_wb(7, 0, 0, 0), 1'b1, "relax_wb3");

    // Same-cycle issue and writeback on one register
    do_reset();
    step(f_ld(3, 1, 'h08, 1, 0), 1'b1, "simul_ld");
    step(f_ldwb(3, 3, 1, 'h08, 1, 0), 1'b1, "simul_both");
    step(f_wb(3, 0, 0, 0), 1'b1, "simul_wb");
    step(f_wb(3, 0, 0, 1), 1'b1, "simul_uf");

    // Flush with issue and writeback in the same cycle
    do_reset();
    step(f_wb(9, 0, 0, 1), 1'b0, "fl_uf");
    step(f_ld(1, 1, 'h02, 1, 1), 1'b0, "fl_ld1");
    step(f_ld(2, 1, 'h06, 2, 1), 1'b0, "fl_ld2");
    step(f_ld(3, 1, 'h0E, 3, 1), 1'b0, "fl_ld3");
    step(mk(1, 4, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1), 1'b0, "fl_flush");
    step(f_ld(1, 1, 'h02, 1, 1), 1'b0, "fl_after");

    // Reset during a stall
    step(f_ld(1, 0, 'h02, 1, 1), 1'b0, "rst_stall");
    @(negedge clock);
    apply_vec(f_ldwb(1, 1, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_busy", busy_s, 0);
    check("midrst_outstanding", out_s, 0);
    check("midrst_err", err_s, 0);
    check("midrst_relax_busy", busy_r, 0);
    check("midrst_relax_err", err_r, 0);
    @(negedge clock);
    reset = 1'b0;
    apply_vec(f_ld(1, 0, 0, 0, 0));
    #1;
    check("midrst_ready", rdy_s, 1);
    check("midrst_relax_ready", rdy_r, 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_ard   = 4'($urandom_range(0, 7));
      iss_ar1   = 4'($urandom_range(0, 7));
      iss_ar2   = 4'($urandom_range(0, 7));
      iss_use1  = 1'($urandom_range(0, 1));
      iss_use2  = 1'($urandom_range(0, 1));
      iss_wen   = ($urandom_range(0, 3) != 0);
      iss_load  = 1'($urandom_range(0, 1));
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_ard    = 4'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      er_s = m_ready(0);
      er_r = m_ready(1);
      check($sformatf("rnd%0d_ready", c), rdy_s, er_s);
      check($sformatf("rnd%0d_relax_ready", c), rdy_r, er_r);
      model_step(0, er_s);
      model_step(1, er_r);
      @(posedge clock);
      #1;
      check($sformatf("rnd%0d_busy", c), busy_s, m_busy(0));
      check($sformatf("rnd%0d_outstanding", c), out_s, out_m[0]);
      check($sformatf("rnd%0d_err", c), err_s, err_m[0]);
      check($sformatf("rnd%0d_relax_busy", c), busy_r, m_busy(1));
      check($sformatf("rnd%0d_relax_outstanding", c), out_r, out_m[1]);
      check($sformatf("rnd%0d_relax_err", c), err_r, err_m[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_lsu_scoreboard.md
Name: ysyx_25040111_lsu_scoreboard

Overview:
- Parametrised read-after-write / write-after-write scoreboard between decode and the execute/load path.
- Generalises the 16-bit single-bit lock vector into per-register pending counters, so several loads can be outstanding at once.
- Adds a global outstanding-load limit, an optional WAW relaxation mode, flush, and underflow error reporting.
- Issue is gated by iss_ready; load writebacks retire pending entries.

Parameters:
- NREG, 16, number of architectural registers tracked (power of 2, >=2).
- AW, 4, register address width, log2(NREG).
- CNT_W, 2, width of each per-register pending counter.
- MAX_OUT, 4, maximum loads in flight across all registers (1..255).
- WAW_STALL, 1, 1 = stall on any pending destination; 0 = allow stacked loads to one destination up to counter max.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- iss_valid  input  1  decode offers an instruction
- iss_ready  output  1  scoreboard accepts the instruction this cycle
- iss_ard  input  AW  destination register
- iss_ar1  input  AW  source register 1
- iss_ar2  input  AW  source register 2
- iss_use1  input  1  ar1 is read
- iss_use2  input  1  ar2 is read
- iss_wen  input  1  instruction writes ard
- iss_load  input  1  instruction is a load (creates a pending entry)
- wb_valid  input  1  a load result is retired this cycle
- wb_ard  input  AW  register retired by the writeback
- flush  input  1  discard all pending state
- busy_vec  output  NREG  bit i = (cnt[i] != 0)
- outstanding  output  8  total loads in flight
- err_underflow  output  1  sticky; set by a writeback to a non-zero register whose counter is 0

Behaviour:
- Reset: reset, synchronous, active-high; clock clock.
  - All cnt[i] = 0, outstanding = 0, err_underflow = 0, busy_vec = 0.
  - iss_ready is 1 after reset when no hazard applies.
- State: cnt[NREG-1:0] (CNT_W bits each), outstanding counter, err_underflow flag.
  - Register 0 is never tracked: cnt[0] is held at 0.
  - Hazard and issue checks ignore register 0.
- Hazard, evaluated combinationally from registered state only (same-cycle writeback does not bypass):
  - raw = (iss_use1 & cnt[ar1]!=0) | (iss_use2 & cnt[ar2]!=0)
  - waw = iss_wen & (WAW_STALL ? cnt[ard]!=0 : cnt[ard]==2^CNT_W-1)
  - full = iss_load & iss_wen & (outstanding == MAX_OUT)
  - iss_ready = ~flush & ~raw & ~waw & ~full. iss_ready does not depend on iss_valid.
- Fire = iss_valid & iss_ready.
  - If fire & iss_load & iss_wen & ard != 0: cnt[ard] += 1 and outstanding += 1 on the next edge.
  - Non-load writers create no entry.
- Writeback: if wb_valid & wb_ard != 0 & cnt[wb_ard] != 0, then cnt[wb_ard] -= 1 and outstanding -= 1.
  - If the counter is 0: no change, and err_underflow is set to 1 (held until reset).
  - wb_ard == 0 is ignored silently.
- Simultaneous issue-increment and writeback-decrement:
  - Same register: cnt is unchanged.
  - Different registers: each register updates independently.
  - outstanding nets to +1, 0 or -1 accordingly.
- Flush has priority over everything:
  - Next edge: all cnt = 0, outstanding = 0.
  - Same-cycle issue and writeback are dropped; err_underflow is unaffected.
  - iss_ready is 0 during the flush cycle.
- Latency: a set or clear is visible in busy_vec and iss_ready one cycle after the triggering edge.
- Counters never wrap. Overflow is prevented by the waw/full terms; underflow is prevented by the error path.
- Reset mid-operation clears all state regardless of other inputs.

Test Plan:
1. Load-use: issue load ard=5, then 1 cycle later an add with ar1=5, use1=1 -> iss_ready=0 and busy_vec=0x0020. Writeback wb_ard=5 -> iss_ready=1 on the following cycle, busy_vec=0.
2. Global limit, MAX_OUT=4: issue loads to x1..x4 back-to-back -> outstanding=4, a fifth load to x6 stalls. One writeback to x2 -> the load to x6 issues one cycle later.
3. WAW modes:
   - WAW_STALL=1: two loads to x7 -> second stalled until x7 retires.
   - WAW_STALL=0, CNT_W=2: three loads to x7 issue, fourth stalls; cnt[7] reaches 3 and busy_vec[7] stays 1 until the third writeback.
4. Simultaneous events: cnt[3]=1, same cycle issue load ard=3 and wb_ard=3 -> cnt[3] stays 1 and outstanding is unchanged.
5. Edge cases:
   - Load with ard=0 -> no busy bit, outstanding unchanged.
   - wb_ard=9 while cnt[9]=0 -> err_underflow=1, sticky through later traffic.
   - wb_ard=0 -> no error.
6. Flush: 3 loads pending plus an issue and a writeback asserted in the flush cycle -> next cycle busy_vec=0, outstanding=0, err_underflow unchanged. Assert reset mid-stall -> all outputs return to their reset values.
